tile_scroller: RTL and testbench
================================

Name: tile_scroller

Overview:
- Upstream producer for the draw/erase sequencer.
- Owns the playfield model: six tile rows, each a 3-bit lane code (0 = empty, 1..4 = black tile in lane 1..4), plus the vertical scroll offset within a row.
- Each frame tick it requests one redraw pass (draw_go) and waits for the sequencer's all_drawing_done. It then advances the scroll; on row wrap it shifts rows down and inserts a pseudo-random new top row.
- Row codes and offset stay frozen while a pass is in progress, so draw/erase engines see stable coordinates.

Parameters:
TICK_DIV, 833333, clock cycles per frame tick (50 MHz / 60 Hz); must be >= 2
ROW_HEIGHT, 40, scroll rows per tile row; offset wraps at this value
STEP, 1, offset increment per completed pass; 1..ROW_HEIGHT-1
LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero

Ports:
clock  in  1  system clock
resetn  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; leaves IDLE and begins scrolling
run  in  1  level; 0 stops scrolling after any pass in flight completes
pause  in  1  level; freezes tick counter, no new passes
all_drawing_done  in  1  sequencer finished erase/draw of all six rows
draw_go  out  1  redraw request to sequencer, held until done observed
row_lanes  out  18  row i lane code at bits [3i+2:3i]; row 0 = top, row 5 = bottom
offset  out  6  current scroll offset, 0..ROW_HEIGHT-1
row_advance  out  1  one-cycle pulse when rows shift
bottom_lane  out  3  lane code of the row that just left row 5; valid with row_advance, held until next shift
overrun  out  1  sticky: a frame tick fired while a pass was in flight
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (resetn=0 at clock edge): state IDLE, draw_go=0, all rows 0, offset=0, row_advance=0, bottom_lane=0, overrun=0, tick counter=0, LFSR=LFSR_SEED. Reset mid-pass drops draw_go on the same edge.
- Tick counter: counts 0..TICK_DIV-1 while state != IDLE and pause=0. tick=1 for the cycle where count==TICK_DIV-1, then the count wraps to 0. Counter holds while pause=1. Counter is cleared on start.
- States: IDLE, WAIT_TICK, DRAW_WAIT, ADVANCE.
- IDLE: on start=1 go to WAIT_TICK and clear overrun. run is ignored in IDLE.
- WAIT_TICK:
  - If run=0, go to IDLE.
  - Else if tick=1, go to DRAW_WAIT and register draw_go=1; draw_go rises the cycle after the tick.
- DRAW_WAIT: draw_go=1. When all_drawing_done=1, go to ADVANCE and drop draw_go on that edge. Any tick seen in this state sets overrun=1.
- ADVANCE (exactly 1 cycle):
  - sum = offset + STEP. If sum >= ROW_HEIGHT: offset <= sum - ROW_HEIGHT; bottom_lane <= row5; row[i] <= row[i-1] for i=5..1; LFSR steps once; row0 <= {1'b0, lfsr_next[1:0]} + 1; row_advance=1 for this cycle. Else offset <= sum.
  - Next state is WAIT_TICK, or IDLE if run=0.
  - A tick in ADVANCE sets overrun.
- Row and offset outputs change only in ADVANCE, never while draw_go=1.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1; fb = l[7]^l[5]^l[4]^l[3]; next = {l[6:0], fb}. It steps only on a row shift. Generated lanes are always 1..4; only reset rows are 0.
- Simultaneous events: start while not IDLE is ignored. Setting pause=1 during DRAW_WAIT does not abort the pass. Deasserting run during DRAW_WAIT does not abort; the pass completes, ADVANCE runs, then the block enters IDLE.

Optional Feature:
- Macro TILE_SCROLLER_NO_REPEAT_EN.
- Defined: if the generated lane equals the current row0 lane, row0 takes (lane mod 4)+1 instead, so consecutive rows never share a lane.
- Undefined: generated lane used as-is; adjacent repeats allowed.

Test Plan:
- Reset, then start with TICK_DIV=4 and all_drawing_done tied to draw_go delayed 1 cycle -> draw_go first rises 4 cycles after start, deasserts 1 cycle after done; offset 0->1; rows all 0; overrun=0.
- STEP=1, ROW_HEIGHT=40, run 40 passes -> on 40th ADVANCE offset=0, row_advance pulses once. With feature undefined, row0=3 (LFSR 0xA5->0x4A), bottom_lane=0; next wrap gives row0=2 (0x95) and row1=3.
- Hold all_drawing_done=0 for 10 cycles with TICK_DIV=4 -> draw_go stays 1, row_lanes/offset unchanged, overrun=1 and stays 1 until next start.
- pause=1 for 20 cycles in WAIT_TICK -> no draw_go, tick counter frozen; resume -> draw_go after remaining count.
- run=0 during DRAW_WAIT -> pass completes, offset advances once, busy=0 the cycle after ADVANCE, no further draw_go.
- resetn=0 mid DRAW_WAIT -> next edge draw_go=0, offset=0, rows=0, state IDLE. With TILE_SCROLLER_NO_REPEAT_EN defined, force repeat via seed -> new row0 != old row0.

Source files
------------

// File: rtl/tile_scroller.sv
// Playfield model and scroll timing for the draw/erase sequencer: six lane-coded
// tile rows plus a vertical offset, advanced once per completed redraw pass.
// Optional feature macro: TILE_SCROLLER_NO_REPEAT_EN (no adjacent rows in the same lane).
module tile_scroller #(
    parameter int unsigned TICK_DIV   = 833333,
    parameter int unsigned ROW_HEIGHT = 40,
    parameter int unsigned STEP       = 1,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        i_start,
    input  logic        i_run,
    input  logic        i_pause,
    input  logic        i_all_drawing_done,
    output logic        o_draw_go,
    output logic [17:0] o_row_lanes,
    output logic [5:0]  o_offset,
    output logic        o_row_advance,
    output logic [2:0]  o_bottom_lane,
    output logic        o_overrun,
    output logic        o_busy
);

    localparam int unsigned CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned OFS_W  = 6;
    localparam int unsigned SUM_W  = OFS_W + 1;
    localparam int unsigned LANE_W = 3;
    localparam int unsigned ROWS   = 6;
    localparam int unsigned ROWS_W = ROWS * LANE_W;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TICK = 2'd1,
        S_DRAW_WAIT = 2'd2,
        S_ADVANCE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_count;
    logic [7:0]          r_lfsr;
    logic [ROWS_W-1:0]   r_rows;
    logic [OFS_W-1:0]    r_offset;
    logic                r_draw_go;
    logic                r_row_advance;
    logic [LANE_W-1:0]   r_bottom_lane;
    logic                r_overrun;
    logic                r_busy;

    logic                w_tick;
    logic                w_start_go;
    logic                w_overrun_set;
    logic                w_shift;
    logic [SUM_W-1:0]    w_sum;
    logic                w_wrap;
    logic [OFS_W-1:0]    w_offset_next;
    logic [7:0]          w_lfsr_next;
    logic [LANE_W-1:0]   w_gen_lane;
    logic [LANE_W-1:0]   w_new_lane;

    // Frame tick only advances while scrolling and not paused
    assign w_tick     = (r_state != S_IDLE) && !i_pause && (r_count == TICK_LAST);
    assign w_start_go = (r_state == S_IDLE) && i_start;

    // Scroll arithmetic, applied only in ADVANCE
    assign w_sum         = SUM_W'(r_offset) + SUM_W'(STEP);
    assign w_wrap        = (w_sum >= SUM_W'(ROW_HEIGHT));
    assign w_offset_next = w_wrap ? OFS_W'(w_sum - SUM_W'(ROW_HEIGHT)) : OFS_W'(w_sum);
    assign w_shift       = (r_state == S_ADVANCE) && w_wrap;

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, stepped once per row shift
    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_gen_lane  = {1'b0, w_lfsr_next[1:0]} + 3'd1;

`ifdef TILE_SCROLLER_NO_REPEAT_EN
    // Bump a repeated lane to the next one so adjacent rows always differ
    always_comb begin
        w_new_lane = w_gen_lane;
        if (w_gen_lane == r_rows[LANE_W-1:0]) begin
            w_new_lane = (w_gen_lane == 3'd4) ? 3'd1 : (w_gen_lane + 3'd1);
        end
    end
`else
    assign w_new_lane = w_gen_lane;
`endif

    // Next-state logic
    always_comb begin
        w_next_state  = r_state;
        w_overrun_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: begin
                if (!i_run) begin
                    w_next_state = S_IDLE;
                end else if (w_tick) begin
                    w_next_state = S_DRAW_WAIT;
                end
            end
            S_DRAW_WAIT: begin
                w_overrun_set = w_tick;
                if (i_all_drawing_done) begin
                    w_next_state = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                w_overrun_set = w_tick;
                w_next_state  = i_run ? S_WAIT_TICK : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register with registered, state-derived handshake outputs
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_draw_go <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_draw_go <= (w_next_state == S_DRAW_WAIT);
            r_busy    <= (w_next_state != S_IDLE);
        end
    end

    // Frame tick counter
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (w_start_go) begin
            r_count <= '0;
        end else if ((r_state != S_IDLE) && !i_pause) begin
            r_count <= w_tick ? '0 : (r_count + CNT_W'(1));
        end
    end

    // Sticky overrun, cleared only by a new start
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_overrun <= 1'b0;
        end else if (w_start_go) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end
    end

    // Playfield update; rows and offset move only at the end of ADVANCE
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_rows        <= '0;
            r_offset      <= '0;
            r_lfsr        <= LFSR_SEED;
            r_bottom_lane <= '0;
            r_row_advance <= 1'b0;
        end else begin
            r_row_advance <= w_shift;
            if (r_state == S_ADVANCE) begin
                r_offset <= w_offset_next;
            end
            if (w_shift) begin
                r_bottom_lane <= r_rows[ROWS_W-1 -: LANE_W];
                r_rows        <= {r_rows[ROWS_W-LANE_W-1:0], w_new_lane};
                r_lfsr        <= w_lfsr_next;
            end
        end
    end

    assign o_draw_go     = r_draw_go;
    assign o_row_lanes   = r_rows;
    assign o_offset      = r_offset;
    assign o_row_advance = r_row_advance;
    assign o_bottom_lane = r_bottom_lane;
    assign o_overrun     = r_overrun;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_tile_scroller.sv
// Directed bench for tile_scroller with TICK_DIV=4; the sequencer is modelled as
// done = draw_go delayed one cycle, with a hold override to stall a pass.
module tb_tile_scroller;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic        run;
    logic        pause;
    logic        all_drawing_done;
    logic        draw_go;
    logic [17:0] row_lanes;
    logic [5:0]  offset;
    logic        row_advance;
    logic [2:0]  bottom_lane;
    logic        overrun;
    logic        busy;

    logic        r_dly;
    logic        hold;
    int          n_total;
    int          n_bad;

    tile_scroller #(
        .TICK_DIV   (4),
        .ROW_HEIGHT (40),
        .STEP       (1),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clock              (clock),
        .resetn             (resetn),
        .i_start            (start),
        .i_run              (run),
        .i_pause            (pause),
        .i_all_drawing_done (all_drawing_done),
        .o_draw_go          (draw_go),
        .o_row_lanes        (row_lanes),
        .o_offset           (offset),
        .o_row_advance      (row_advance),
        .o_bottom_lane      (bottom_lane),
        .o_overrun          (overrun),
        .o_busy             (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) r_dly <= resetn ? draw_go : 1'b0;
    assign all_drawing_done = r_dly & ~hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_draw_go(input logic lvl, input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (draw_go === lvl) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    // Step until a row shift is seen; reports the offset just before it
    task automatic wait_shift(input int budget, output logic found, output logic [5:0] prev);
        found = 1'b0;
        prev  = offset;
        for (int i = 0; i < budget; i++) begin
            prev = offset;
            step(1);
            if (row_advance === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic        found;
        logic [5:0]  prev;
        logic [17:0] held_rows;
        logic [5:0]  held_ofs;
        n_total = 0;
        n_bad   = 0;
        resetn  = 1'b0;
        start   = 1'b0;
        run     = 1'b0;
        pause   = 1'b0;
        hold    = 1'b0;
        step(3);
        resetn = 1'b1;
        step(1);
        chk("rst_draw_go", 32'(draw_go), 32'd0);
        chk("rst_rows", 32'(row_lanes), 32'd0);
        chk("rst_offset", 32'(offset), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_bottom", 32'(bottom_lane), 32'd0);

        // First pass timing: draw_go rises 4 cycles after the start edge
        run   = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk("pre_tick_draw_go", 32'(draw_go), 32'd0);
        end
        step(1);
        chk("first_draw_go", 32'(draw_go), 32'd1);
        step(1);
        chk("draw_go_hold_until_done", 32'(draw_go), 32'd1);
        step(1);
        chk("draw_go_drop", 32'(draw_go), 32'd0);
        chk("offset_frozen_in_advance", 32'(offset), 32'd0);
        step(1);
        chk("offset_first_pass", 32'(offset), 32'd1);
        chk("rows_first_pass", 32'(row_lanes), 32'd0);
        chk("overrun_first_pass", 32'(overrun), 32'd0);

        // First row wrap after 40 passes
        wait_shift(400, found, prev);
        chk("wrap1_seen", 32'(found), 32'd1);
        chk("wrap1_prev_offset", 32'(prev), 32'd39);
        chk("wrap1_offset", 32'(offset), 32'd0);
        chk("wrap1_rows", 32'(row_lanes), 32'h3);
        chk("wrap1_bottom", 32'(bottom_lane), 32'd0);
        step(1);
        chk("wrap1_pulse_one_cycle", 32'(row_advance), 32'd0);

        // Second wrap: row0=2 from LFSR 0x95, old row0 moves to row1
        wait_shift(400, found, prev);
        chk("wrap2_seen", 32'(found), 32'd1);
        chk("wrap2_rows", 32'(row_lanes), 32'h1A);
        chk("wrap2_bottom", 32'(bottom_lane), 32'd0);

        // Stalled pass: coordinates frozen and overrun latched
        wait_draw_go(1'b1, 20, found);
        chk("stall_draw_go_seen", 32'(found), 32'd1);
        hold      = 1'b1;
        held_rows = row_lanes;
        held_ofs  = offset;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("stall_draw_go", 32'(draw_go), 32'd1);
        end
        chk("stall_rows", 32'(row_lanes), 32'(held_rows));
        chk("stall_offset", 32'(offset), 32'(held_ofs));
        chk("stall_overrun", 32'(overrun), 32'd1);
        hold = 1'b0;
        step(3);
        chk("stall_offset_advanced", 32'(offset), 32'(held_ofs + 6'd1));
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Stop, then restart and pause at count 1
        run = 1'b0;
        for (int k = 0; k < 20 && busy; k++) step(1);
        chk("stopped", 32'(busy), 32'd0);
        run   = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("restart_overrun_clear", 32'(overrun), 32'd0);
        step(1);
        pause = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            chk("pause_no_draw_go", 32'(draw_go), 32'd0);
        end
        pause = 1'b0;
        step(2);
        chk("resume_draw_go_early", 32'(draw_go), 32'd0);
        step(1);
        chk("resume_draw_go", 32'(draw_go), 32'd1);

        // run=0 during DRAW_WAIT lets the pass finish, then idles
        held_ofs = offset;
        run = 1'b0;
        step(2);
        chk("stop_draw_go_drop", 32'(draw_go), 32'd0);
        chk("stop_busy_in_advance", 32'(busy), 32'd1);
        step(1);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_offset", 32'(offset), 32'(held_ofs + 6'd1));
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("stop_no_draw_go", 32'(draw_go), 32'd0);
        end

        // Reset mid DRAW_WAIT
        run   = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_draw_go(1'b1, 20, found);
        chk("rst_mid_draw_go_seen", 32'(found), 32'd1);
        hold = 1'b1;
        step(2);
        resetn = 1'b0;
        step(1);
        chk("rst_mid_draw_go", 32'(draw_go), 32'd0);
        chk("rst_mid_offset", 32'(offset), 32'd0);
        chk("rst_mid_rows", 32'(row_lanes), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        hold   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("idle_after_rst", 32'(draw_go), 32'd0);
        end

        // LFSR reseeded: first wrap again yields lane 3
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_shift(400, found, prev);
        chk("reseed_wrap_seen", 32'(found), 32'd1);
        chk("reseed_rows", 32'(row_lanes), 32'h3);

        run = 1'b0;
        step(2);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
